// File: rtl/wb_trace_if.sv
// Signal bundle between the writeback stage / trace consumer and wb_trace_buffer.
// master: the core side that retires instructions and drains the trace.
// slave:  the trace buffer itself.
interface wb_trace_if #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // writeback observation and pop request
    logic              wb_valid;
    logic              wb_reg_write;
    logic [4:0]        write_reg_wb;
    logic [31:0]       result_wb;
    logic [31:0]       pc_wb;
    logic              stall;
    logic              rd_en;

    // popped entry, occupancy and counters
    logic              rd_valid;
    logic [4:0]        rd_reg;
    logic [31:0]       rd_data;
    logic [31:0]       rd_pc;
    logic [CYC_W-1:0]  rd_cycle;
    logic [CNT_W-1:0]  count;
    logic              empty;
    logic              full;
    logic [CYC_W-1:0]  retire_cnt;
    logic [CYC_W-1:0]  stall_cnt;
    logic [CYC_W-1:0]  overflow_cnt;

    modport master (
        output wb_valid, wb_reg_write, write_reg_wb, result_wb, pc_wb, stall, rd_en,
        input  rd_valid, rd_reg, rd_data, rd_pc, rd_cycle, count, empty, full,
               retire_cnt, stall_cnt, overflow_cnt
    );

    modport slave (
        input  wb_valid, wb_reg_write, write_reg_wb, result_wb, pc_wb, stall, rd_en,
        output rd_valid, rd_reg, rd_data, rd_pc, rd_cycle, count, empty, full,
               retire_cnt, stall_cnt, overflow_cnt
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback commit-trace buffer: stores every retired register write
// (dest, value, PC, cycle stamp) in an ordered FIFO and keeps saturating
// retire / stall / overflow counters.
// Build option: define WB_TRACE_FILTER_R0_EN to ignore writes to $0
// (neither stored nor counted as retired).
module wb_trace_buffer #(
    parameter int DEPTH = 16,
    parameter int CYC_W = 32
) (
    input  logic       clk,
    input  logic       reset,
    wb_trace_if.slave  bus
);
    localparam int addr_w = $clog2(DEPTH);
    localparam int cnt_w  = addr_w + 1;
    localparam logic [cnt_w-1:0] full_level = cnt_w'(DEPTH);

    typedef struct packed {
        logic [4:0]       dest;
        logic [31:0]      data;
        logic [31:0]      pc;
        logic [CYC_W-1:0] stamp;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [addr_w-1:0]  wr_ptr;
    logic [addr_w-1:0]  rd_ptr;
    logic [cnt_w-1:0]   count_q;
    logic [CYC_W-1:0]   cyc;
    logic [CYC_W-1:0]   retire_q;
    logic [CYC_W-1:0]   stall_q;
    logic [CYC_W-1:0]   overflow_q;
    logic               rd_valid_q;
    entry_t             rd_q;

    logic cap;
    logic pop;
    logic push;
    logic drop;
    logic empty_w;
    logic full_w;

    function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

`ifdef WB_TRACE_FILTER_R0_EN
    assign cap = bus.wb_valid & bus.wb_reg_write & (bus.write_reg_wb != 5'd0);
`else
    assign cap = bus.wb_valid & bus.wb_reg_write;
`endif

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == full_level);
    // empty is sampled, so a pop on an empty FIFO is never granted even
    // when a push lands in the same cycle.
    assign pop  = bus.rd_en & ~empty_w;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push = cap & (~full_w | pop);
    assign drop = cap & full_w & ~pop;

    // Entry storage: written at the tail on every accepted push.
    // NOTE: the storage array has no reset; occupancy is tracked by the pointers
    // and count, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{dest: bus.write_reg_wb, data: bus.result_wb,
                             pc: bus.pc_wb, stamp: cyc};
        end
    end

    // Pointers and occupancy count.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // Free-running cycle stamp and saturating event counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc        <= '0;
            retire_q   <= '0;
            stall_q    <= '0;
            overflow_q <= '0;
        end else begin
            cyc <= cyc + 1'b1;
            if (cap)       retire_q   <= sat_inc(retire_q);
            if (bus.stall) stall_q    <= sat_inc(stall_q);
            if (drop)      overflow_q <= sat_inc(overflow_q);
        end
    end

    // Registered read port: one-cycle pulse per pop, fields hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_q       <= '0;
        end else begin
            rd_valid_q <= pop;
            if (pop) rd_q <= mem[rd_ptr];
        end
    end

    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_reg       = rd_q.dest;
    assign bus.rd_data      = rd_q.data;
    assign bus.rd_pc        = rd_q.pc;
    assign bus.rd_cycle     = rd_q.stamp;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.retire_cnt   = retire_q;
    assign bus.stall_cnt    = stall_q;
    assign bus.overflow_cnt = overflow_q;
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: scoreboard of expected trace
// entries plus a hand-derived vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_wb_trace_buffer;
    localparam int DEPTH = 16;
    localparam int CYC_W = 32;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_trace_if #(.DEPTH(DEPTH), .CYC_W(CYC_W)) bus ();

    wb_trace_buffer #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic [31:0] pc;
        logic [31:0] stamp;
    } ent_t;

    typedef struct {
        logic        v;
        logic        rw;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [31:0] pc;
        logic        st;
        logic        rd;
        logic        exp_valid;
        logic [31:0] exp_data;
        int          exp_count;
    } vec_t;

    ent_t        sb[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] m_cyc, m_retire, m_stall, m_ovf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    task automatic drive_idle();
        bus.wb_valid = 0; bus.wb_reg_write = 0; bus.write_reg_wb = 0;
        bus.result_wb = 0; bus.pc_wb = 0; bus.stall = 0; bus.rd_en = 0;
    endtask

    // One clock: drive inputs, predict, advance, compare against the scoreboard.
    task automatic step(input logic v, input logic rw, input logic [4:0] dst,
                        input logic [31:0] data, input logic [31:0] pc,
                        input logic st, input logic rd);
        logic cap, pop, push;
        ent_t e, got;
        bus.wb_valid = v; bus.wb_reg_write = rw; bus.write_reg_wb = dst;
        bus.result_wb = data; bus.pc_wb = pc; bus.stall = st; bus.rd_en = rd;
        cap = v && rw;
`ifdef WB_TRACE_FILTER_R0_EN
        cap = cap && (dst != 5'd0);
`endif
        pop  = rd && (sb.size() != 0);
        push = cap && ((sb.size() < DEPTH) || pop);
        if (cap && !push) m_ovf++;
        if (cap) m_retire++;
        if (st)  m_stall++;
        e = '{dst, data, pc, m_cyc};
        @(posedge clk); #1;
        m_cyc++;
        got = '{5'd0, 32'd0, 32'd0, 32'd0};
        if (pop)  got = sb.pop_front();
        if (push) sb.push_back(e);
        check("rd_valid", bus.rd_valid, pop);
        if (bus.rd_valid && pop) begin
            check("sb_rd_reg",   bus.rd_reg,   got.dest);
            check("sb_rd_data",  bus.rd_data,  got.data);
            check("sb_rd_pc",    bus.rd_pc,    got.pc);
            check("sb_rd_cycle", bus.rd_cycle, got.stamp);
        end
        check("count",        bus.count,        sb.size());
        check("empty",        bus.empty,        sb.size() == 0);
        check("full",         bus.full,         sb.size() == DEPTH);
        check("retire_cnt",   bus.retire_cnt,   m_retire);
        check("stall_cnt",    bus.stall_cnt,    m_stall);
        check("overflow_cnt", bus.overflow_cnt, m_ovf);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_rd_valid"}, bus.rd_valid, 0);
        check({tag, "_rd_reg"},   bus.rd_reg,   0);
        check({tag, "_rd_data"},  bus.rd_data,  0);
        check({tag, "_rd_pc"},    bus.rd_pc,    0);
        check({tag, "_rd_cycle"}, bus.rd_cycle, 0);
        check({tag, "_count"},    bus.count,    0);
        check({tag, "_empty"},    bus.empty,    1);
        check({tag, "_full"},     bus.full,     0);
        check({tag, "_retire"},   bus.retire_cnt,   0);
        check({tag, "_stall"},    bus.stall_cnt,    0);
        check({tag, "_overflow"}, bus.overflow_cnt, 0);
    endtask

    task automatic reset_model();
        sb.delete();
        m_cyc = 0; m_retire = 0; m_stall = 0; m_ovf = 0;
    endtask

    vec_t t1[8];

    initial begin
        // commit sequence with a stall bubble, then a full drain
        t1[0] = '{1, 1, 5'd1, 32'd50,  32'h00, 0, 0, 0, 32'h00, 1};
        t1[1] = '{1, 1, 5'd2, 32'd50,  32'h04, 0, 0, 0, 32'h00, 2};
        t1[2] = '{0, 0, 5'd0, 32'd0,   32'h08, 1, 0, 0, 32'h00, 2};
        t1[3] = '{1, 1, 5'd3, 32'd100, 32'h0C, 0, 0, 0, 32'h00, 3};
        t1[4] = '{0, 0, 5'd0, 32'd0,   32'h00, 0, 1, 1, 32'h32, 2};
        t1[5] = '{0, 0, 5'd0, 32'd0,   32'h00, 0, 1, 1, 32'h32, 1};
        t1[6] = '{0, 0, 5'd0, 32'd0,   32'h00, 0, 1, 1, 32'h64, 0};
        t1[7] = '{0, 0, 5'd0, 32'd0,   32'h00, 0, 1, 0, 32'h64, 0};

        drive_idle();
        reset_model();
        #1 reset = 1'b1;
        #1 check_reset_state("por");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        reset_model();

        // ---- basic ordered trace with a stall cycle ----
        for (int i = 0; i < 8; i++) begin
            step(t1[i].v, t1[i].rw, t1[i].dst, t1[i].data, t1[i].pc, t1[i].st, t1[i].rd);
            check($sformatf("t1_valid[%0d]", i), bus.rd_valid, t1[i].exp_valid);
            check($sformatf("t1_data[%0d]", i),  bus.rd_data,  t1[i].exp_data);
            check($sformatf("t1_count[%0d]", i), bus.count,    t1[i].exp_count);
        end
        check("t1_stall_cnt",  bus.stall_cnt,  1);
        check("t1_retire_cnt", bus.retire_cnt, 3);

        // ---- overfill: DEPTH+3 pushes without popping ----
        for (int i = 0; i < DEPTH + 3; i++)
            step(1, 1, 5'((i % 31) + 1), 32'h1000 + i, 32'h100 + 4 * i, 0, 0);
        check("ovf_full",     bus.full,         1);
        check("ovf_count",    bus.count,        DEPTH);
        check("ovf_overflow", bus.overflow_cnt, 3);

        // ---- full FIFO: capture and pop in the same cycle ----
        step(1, 1, 5'd7, 32'hBEEF, 32'h200, 0, 1);
        check("fp_count",    bus.count,        DEPTH);
        check("fp_overflow", bus.overflow_cnt, 3);
        check("fp_head",     bus.rd_data,      32'h1000);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 0, 0, 0, 0, 1);
        check("fp_tail", bus.rd_data, 32'hBEEF);
        check("fp_empty", bus.empty, 1);

        // ---- rd_en on empty FIFO with a capture in the second cycle ----
        step(0, 0, 0, 0, 0, 0, 1);
        check("er_hold_data", bus.rd_data, 32'hBEEF);
        check("er_valid1",    bus.rd_valid, 0);
        step(1, 1, 5'd9, 32'h55, 32'h300, 0, 1);
        check("er_valid2",    bus.rd_valid, 0);
        check("er_count2",    bus.count, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        check("er_valid3",    bus.rd_valid, 1);
        check("er_data3",     bus.rd_data, 32'h55);
        check("er_reg3",      bus.rd_reg, 9);

        // ---- write to $0 ----
        step(1, 1, 5'd0, 32'hDEAD, 32'h400, 0, 0);
`ifdef WB_TRACE_FILTER_R0_EN
        check("r0_count",  bus.count,      0);
        check("r0_retire", bus.retire_cnt, 24);
`else
        check("r0_count",  bus.count,      1);
        check("r0_retire", bus.retire_cnt, 25);
        step(0, 0, 0, 0, 0, 0, 1);
        check("r0_rd_reg",  bus.rd_reg,  0);
        check("r0_rd_data", bus.rd_data, 32'hDEAD);
`endif

        // ---- asynchronous reset while holding 5 entries ----
        for (int i = 0; i < 5; i++) step(1, 1, 5'(i + 10), 32'h500 + i, 32'h500 + 4 * i, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("mr_count", bus.count, 4);
        drive_idle();
        #2 reset = 1'b1;
        #1 check_reset_state("mr");
        @(posedge clk);
        #1 reset = 1'b0;
        reset_model();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 5'd4, 32'h77, 32'h600, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        check("mr_rd_cycle", bus.rd_cycle, 4);
        check("mr_rd_data",  bus.rd_data,  32'h77);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
